// File: rtl/reg_bank_dec_pkg.sv
// Shared defaults for the register bank and its bus interface.
package reg_bank_dec_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_bank_dec_if.sv
// Write/read/control bus of the register bank; master drives requests, slave is the bank.
interface reg_bank_dec_if
  import reg_bank_dec_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                 en;
  logic                 clr;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic [2**ADDR_W-1:0] wr_sel;

  modport master (
    output en, clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_sel
  );

  modport slave (
    input  en, clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, wr_sel
  );

endinterface

// File: rtl/dec_n_onehot.sv
// Generic n-to-2^n one-hot decoder; all outputs low when en is low.
module dec_n_onehot #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]    in,
  input  logic               en,
  output logic [2**N_IN-1:0] out
);

  // NOTE: assigning a default before the conditional keeps this purely combinational (no latch).
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_dec.sv
// Register bank: one-hot decoded write port, registered read port, global enable and sync clear.
module reg_bank_dec
  import reg_bank_dec_pkg::*;
#(
  parameter int                WIDTH   = DEF_WIDTH,
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter int                BYPASS  = 0
) (
  input logic           clk,
  input logic           rst_n,
  reg_bank_dec_if.slave bus
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] wr_sel;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    rd_next;

  dec_n_onehot #(.N_IN(ADDR_W)) u_dec (
    .in  (bus.wr_addr),
    .en  (bus.en & bus.wr_en & ~bus.clr),
    .out (wr_sel)
  );

  assign bus.wr_sel = wr_sel;

  // NOTE: the storage is built from flops rather than a RAM because every entry needs a reset value.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= RST_VAL;
      end else if (bus.en) begin
        if (bus.clr)        regs[i] <= RST_VAL;
        else if (wr_sel[i]) regs[i] <= bus.wr_data;
      end
    end
  end

  // With bypass, a same-edge clear or write to the read address wins over the stored value.
  always_comb begin
    rd_next = regs[bus.rd_addr];
    if (BYPASS != 0) begin
      if (bus.clr)                   rd_next = RST_VAL;
      else if (wr_sel[bus.rd_addr])  rd_next = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else if (bus.en) begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_next;
    end
  end

endmodule
